// File: rtl/stamp_ctrl.sv
// -----------------------------------------------------------------------------
// stamp_ctrl
//
// Owns the running Unix timestamp and sequences it through an external
// stamp2time converter. The counter is updated by one of four events (set,
// adjust, 1 Hz tick, or the post-reset initial conversion). After each update
// the controller waits for the converter latency and then captures the BCD
// date/time fields into the display registers.
//
// Parameters
//   CONV_LAT     cycles from a counter change until converter outputs are
//                valid (1..15)
//   RESET_STAMP  counter value loaded by reset
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   tick_1hz                 one-cycle pulse per second
//   set_req/set_stamp        level request to load set_stamp
//   set_ack                  one-cycle acceptance pulse for set
//   adj_req/adj_unit/adj_dir level request to step the counter
//                            (unit 0..3 = s/min/h/day, dir 0 add, 1 subtract)
//   adj_ack                  one-cycle acceptance pulse for adjust
//   counter                  timestamp feeding the converter
//   *_bcd                    converter outputs
//   disp_*                   captured date/time fields
//   disp_valid               one-cycle pulse when disp_* update
//   busy                     high whenever a conversion is in progress
//   overrun                  sticky: a tick was dropped
//
// Optional build macro STAMP_CTRL_ALARM_EN adds alarm_stamp, alarm_en and
// alarm_hit; alarm_hit pulses once when a captured counter equals
// alarm_stamp while alarm_en is high.
//
// State table
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for set / adjust / tick / initial conversion
//   ST_WAIT    | counter changed, waiting CONV_LAT cycles for the converter
//   ST_CAPTURE | converter outputs valid, load disp_* on this edge
// -----------------------------------------------------------------------------
module stamp_ctrl #(
    parameter int unsigned CONV_LAT    = 2,
    parameter logic [63:0] RESET_STAMP = 64'd1704067200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1hz,
    input  logic        set_req,
    input  logic [63:0] set_stamp,
    output logic        set_ack,
    input  logic        adj_req,
    input  logic [1:0]  adj_unit,
    input  logic        adj_dir,
    output logic        adj_ack,
    output logic [63:0] counter,
    input  logic [15:0] year_bcd,
    input  logic [7:0]  month_bcd,
    input  logic [7:0]  day_bcd,
    input  logic [7:0]  hour_bcd,
    input  logic [7:0]  minute_bcd,
    input  logic [7:0]  second_bcd,
    output logic [15:0] disp_year,
    output logic [7:0]  disp_month,
    output logic [7:0]  disp_day,
    output logic [7:0]  disp_hour,
    output logic [7:0]  disp_minute,
    output logic [7:0]  disp_second,
    output logic        disp_valid,
    output logic        busy,
    output logic        overrun
`ifdef STAMP_CTRL_ALARM_EN
   ,input  logic [63:0] alarm_stamp,
    input  logic        alarm_en,
    output logic        alarm_hit
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(CONV_LAT - 1);

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic [63:0] counter_nxt;
    logic        tick_pend, tick_pend_nxt;
    logic        init_pend, init_pend_nxt;
    logic        overrun_nxt;
    logic        set_ack_nxt, adj_ack_nxt;
    logic        capture;
    logic        park_tick;
    logic [63:0] adj_step;
    logic [63:0] adj_result;

    always_comb begin
        adj_step = 64'd1;
        case (adj_unit)
            2'd0:    adj_step = 64'd1;
            2'd1:    adj_step = 64'd60;
            2'd2:    adj_step = 64'd3600;
            default: adj_step = 64'd86400;
        endcase
    end

    // Add wraps naturally; subtract clamps at zero instead of wrapping.
    always_comb begin
        adj_result = counter + adj_step;
        if (adj_dir) begin
            adj_result = (adj_step > counter) ? 64'd0 : (counter - adj_step);
        end
    end

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        counter_nxt   = counter;
        tick_pend_nxt = tick_pend;
        init_pend_nxt = init_pend;
        overrun_nxt   = overrun;
        set_ack_nxt   = 1'b0;
        adj_ack_nxt   = 1'b0;
        capture       = 1'b0;
        park_tick     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (set_req) begin
                    counter_nxt  = set_stamp;
                    set_ack_nxt  = 1'b1;
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = 4'd0;
                    park_tick    = tick_1hz;
                end else if (adj_req) begin
                    counter_nxt  = adj_result;
                    adj_ack_nxt  = 1'b1;
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = 4'd0;
                    park_tick    = tick_1hz;
                end else if (tick_1hz || tick_pend) begin
                    counter_nxt  = counter + 64'd1;
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = 4'd0;
                    // The pending slot frees as it is consumed, so a fresh
                    // tick on the same edge simply refills it.
                    if (tick_pend) begin
                        tick_pend_nxt = tick_1hz;
                    end
                end else if (init_pend) begin
                    init_pend_nxt = 1'b0;
                    state_nxt     = ST_WAIT;
                    wait_cnt_nxt  = 4'd0;
                end
            end
            ST_WAIT: begin
                park_tick = tick_1hz;
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_CAPTURE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            ST_CAPTURE: begin
                park_tick    = tick_1hz;
                capture      = 1'b1;
                state_nxt    = ST_IDLE;
                wait_cnt_nxt = 4'd0;
            end
            default: begin
                state_nxt    = ST_IDLE;
                wait_cnt_nxt = 4'd0;
            end
        endcase

        // Tick that could not be consumed this cycle: one-deep buffer, a
        // second one while the buffer is full is lost and flagged.
        if (park_tick) begin
            if (tick_pend) begin
                overrun_nxt = 1'b1;
            end else begin
                tick_pend_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            counter   <= RESET_STAMP;
            tick_pend <= 1'b0;
            init_pend <= 1'b1;
            overrun   <= 1'b0;
            set_ack   <= 1'b0;
            adj_ack   <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            counter   <= counter_nxt;
            tick_pend <= tick_pend_nxt;
            init_pend <= init_pend_nxt;
            overrun   <= overrun_nxt;
            set_ack   <= set_ack_nxt;
            adj_ack   <= adj_ack_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_year   <= 16'd0;
            disp_month  <= 8'd0;
            disp_day    <= 8'd0;
            disp_hour   <= 8'd0;
            disp_minute <= 8'd0;
            disp_second <= 8'd0;
            disp_valid  <= 1'b0;
        end else begin
            disp_valid <= capture;
            if (capture) begin
                disp_year   <= year_bcd;
                disp_month  <= month_bcd;
                disp_day    <= day_bcd;
                disp_hour   <= hour_bcd;
                disp_minute <= minute_bcd;
                disp_second <= second_bcd;
            end
        end
    end

`ifdef STAMP_CTRL_ALARM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hit <= 1'b0;
        end else begin
            alarm_hit <= capture && alarm_en && (counter == alarm_stamp);
        end
    end
`endif

endmodule

// File: tb/tb_stamp_ctrl.sv
module tb_stamp_ctrl;

    localparam int unsigned CONV_LAT    = 2;
    localparam logic [63:0] RESET_STAMP = 64'd1704067200;
    localparam int K_SET  = 0;
    localparam int K_ADJ  = 1;
    localparam int K_TICK = 2;

    typedef struct packed {
        logic [15:0] year;
        logic [7:0]  mon;
        logic [7:0]  day;
        logic [7:0]  hour;
        logic [7:0]  min;
        logic [7:0]  sec;
    } date_t;

    typedef struct {
        logic [63:0] cnt;
        date_t       d;
    } exp_t;

    typedef struct {
        int          kind;
        logic [63:0] stamp;
        logic [1:0]  unit;
        logic        dir;
        logic [63:0] exp_cnt;
        bit          chk_date;
        date_t       date;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_1hz = 1'b0;
    logic        set_req = 1'b0;
    logic [63:0] set_stamp = 64'd0;
    logic        set_ack;
    logic        adj_req = 1'b0;
    logic [1:0]  adj_unit = 2'd0;
    logic        adj_dir = 1'b0;
    logic        adj_ack;
    logic [63:0] counter;
    logic [15:0] year_bcd;
    logic [7:0]  month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd;
    logic [15:0] disp_year;
    logic [7:0]  disp_month, disp_day, disp_hour, disp_minute, disp_second;
    logic        disp_valid;
    logic        busy;
    logic        overrun;
`ifdef STAMP_CTRL_ALARM_EN
    logic [63:0] alarm_stamp = RESET_STAMP + 64'd5;
    logic        alarm_en = 1'b1;
    logic        alarm_hit;
`endif

    int   checks = 0;
    int   errors = 0;
    int   disp_cnt = 0;
    int   alarm_cnt = 0;
    exp_t sb_q[$];

    stamp_ctrl #(.CONV_LAT(CONV_LAT), .RESET_STAMP(RESET_STAMP)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .set_req(set_req), .set_stamp(set_stamp), .set_ack(set_ack),
        .adj_req(adj_req), .adj_unit(adj_unit), .adj_dir(adj_dir), .adj_ack(adj_ack),
        .counter(counter),
        .year_bcd(year_bcd), .month_bcd(month_bcd), .day_bcd(day_bcd),
        .hour_bcd(hour_bcd), .minute_bcd(minute_bcd), .second_bcd(second_bcd),
        .disp_year(disp_year), .disp_month(disp_month), .disp_day(disp_day),
        .disp_hour(disp_hour), .disp_minute(disp_minute), .disp_second(disp_second),
        .disp_valid(disp_valid), .busy(busy), .overrun(overrun)
`ifdef STAMP_CTRL_ALARM_EN
       ,.alarm_stamp(alarm_stamp), .alarm_en(alarm_en), .alarm_hit(alarm_hit)
`endif
    );

    always #5 clk = ~clk;

    // Unix seconds -> BCD calendar fields (UTC, proleptic Gregorian).
    function automatic logic [7:0] bcd2(input longint unsigned v);
        return {4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic date_t stamp2time(input logic [63:0] t);
        longint unsigned days, s, z, era, doe, yoe, y, doy, mp, d, m, yy;
        date_t r;
        days = t / 86400;
        s    = t % 86400;
        z    = days + 719468;
        era  = z / 146097;
        doe  = z - era * 146097;
        yoe  = (doe - doe / 1460 + doe / 36524 - doe / 146096) / 365;
        y    = yoe + era * 400;
        doy  = doe - (365 * yoe + yoe / 4 - yoe / 100);
        mp   = (5 * doy + 2) / 153;
        d    = doy - (153 * mp + 2) / 5 + 1;
        m    = (mp < 10) ? mp + 3 : mp - 9;
        if (m <= 2) y = y + 1;
        yy = y % 10000;
        r.year = {4'(yy / 1000), 4'((yy / 100) % 10), 4'((yy / 10) % 10), 4'(yy % 10)};
        r.mon  = bcd2(m);
        r.day  = bcd2(d);
        r.hour = bcd2(s / 3600);
        r.min  = bcd2((s / 60) % 60);
        r.sec  = bcd2(s % 60);
        return r;
    endfunction

    // Converter model: outputs reflect counter CONV_LAT edges after it changes.
    logic [63:0] pipe [CONV_LAT];
    date_t       conv_out;
    always @(posedge clk) begin
        pipe[0] <= counter;
        for (int i = 1; i < int'(CONV_LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign conv_out   = stamp2time(pipe[CONV_LAT-1]);
    assign year_bcd   = conv_out.year;
    assign month_bcd  = conv_out.mon;
    assign day_bcd    = conv_out.day;
    assign hour_bcd   = conv_out.hour;
    assign minute_bcd = conv_out.min;
    assign second_bcd = conv_out.sec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    function automatic exp_t mk_exp(input logic [63:0] c);
        exp_t e;
        e.cnt = c;
        e.d   = stamp2time(c);
        return e;
    endfunction

    function automatic vec_t mkv(input int k, input logic [63:0] st, input logic [1:0] u,
                                 input logic dr, input logic [63:0] ec, input bit cd,
                                 input date_t dt);
        vec_t v;
        v.kind = k; v.stamp = st; v.unit = u; v.dir = dr;
        v.exp_cnt = ec; v.chk_date = cd; v.date = dt;
        return v;
    endfunction

    // Scoreboard: every disp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && disp_valid) begin
            disp_cnt++;
            if (sb_q.size() == 0) begin
                chk("disp_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_counter", counter, e.cnt);
                chk("sb_date", 64'({disp_year, disp_month, disp_day, disp_hour,
                                    disp_minute, disp_second}), 64'(e.d));
            end
        end
`ifdef STAMP_CTRL_ALARM_EN
        if (rst_n && alarm_hit) alarm_cnt++;
`endif
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || sb_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk1("wait_idle_timeout", busy || (sb_q.size() != 0), 1'b0);
    endtask

    task automatic do_event(input vec_t v, input string tag);
        @(negedge clk);
        case (v.kind)
            K_SET:   begin set_req = 1'b1; set_stamp = v.stamp; end
            K_ADJ:   begin adj_req = 1'b1; adj_unit = v.unit; adj_dir = v.dir; end
            default: tick_1hz = 1'b1;
        endcase
        sb_q.push_back(mk_exp(v.exp_cnt));
        @(negedge clk);
        chk({tag, "_counter"}, counter, v.exp_cnt);
        chk1({tag, "_busy"}, busy, 1'b1);
        chk1({tag, "_set_ack"}, set_ack, v.kind == K_SET);
        chk1({tag, "_adj_ack"}, adj_ack, v.kind == K_ADJ);
        set_req = 1'b0; adj_req = 1'b0; tick_1hz = 1'b0;
        @(negedge clk);
        chk1({tag, "_ack_len"}, set_ack || adj_ack, 1'b0);
        wait_idle(20);
        if (v.chk_date)
            chk({tag, "_date"}, 64'({disp_year, disp_month, disp_day, disp_hour,
                                     disp_minute, disp_second}), 64'(v.date));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("rst_counter", counter, RESET_STAMP);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_disp_valid", disp_valid, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
        chk1("rst_acks", set_ack || adj_ack, 1'b0);
        chk("rst_disp", 64'({disp_year, disp_month, disp_day, disp_hour,
                             disp_minute, disp_second}), 64'd0);
        repeat (2) @(negedge clk);
        sb_q.push_back(mk_exp(RESET_STAMP));
        rst_n = 1'b1;
    endtask

    vec_t vecs[15];

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dc;
        vecs[0]  = mkv(K_SET,  64'd1724928890, 2'd0, 1'b0, 64'd1724928890, 1'b1,
                       {16'h2024, 8'h08, 8'h29, 8'h10, 8'h54, 8'h50});
        vecs[1]  = mkv(K_SET,  64'd1924991999, 2'd0, 1'b0, 64'd1924991999, 1'b1,
                       {16'h2030, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59});
        vecs[2]  = mkv(K_TICK, 64'd0, 2'd0, 1'b0, 64'd1924992000, 1'b1,
                       {16'h2031, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00});
        vecs[3]  = mkv(K_SET,  64'd30, 2'd0, 1'b0, 64'd30, 1'b0, 56'd0);
        vecs[4]  = mkv(K_ADJ,  64'd0, 2'd1, 1'b1, 64'd0, 1'b0, 56'd0);
        vecs[5]  = mkv(K_ADJ,  64'd0, 2'd3, 1'b0, 64'd86400, 1'b1,
                       {16'h1970, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00});
        vecs[6]  = mkv(K_ADJ,  64'd0, 2'd2, 1'b0, 64'd90000, 1'b0, 56'd0);
        vecs[7]  = mkv(K_ADJ,  64'd0, 2'd0, 1'b1, 64'd89999, 1'b0, 56'd0);
        vecs[8]  = mkv(K_ADJ,  64'd0, 2'd2, 1'b1, 64'd86399, 1'b0, 56'd0);
        vecs[9]  = mkv(K_ADJ,  64'd0, 2'd3, 1'b1, 64'd0, 1'b0, 56'd0);
        vecs[10] = mkv(K_SET,  64'hFFFF_FFFF_FFFF_FFFF, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 56'd0);
        vecs[11] = mkv(K_TICK, 64'd0, 2'd0, 1'b0, 64'd0, 1'b0, 56'd0);
        vecs[12] = mkv(K_SET,  64'hFFFF_FFFF_FFFF_FFC4, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFC4, 1'b0, 56'd0);
        vecs[13] = mkv(K_ADJ,  64'd0, 2'd1, 1'b0, 64'd0, 1'b0, 56'd0);
        vecs[14] = mkv(K_ADJ,  64'd0, 2'd0, 1'b1, 64'd0, 1'b0, 56'd0);

        // Reset with no stimulus: initial conversion lands on edge CONV_LAT+2.
        apply_reset();
        repeat (CONV_LAT + 1) @(posedge clk);
        @(negedge clk);
        chk1("init_dv_early", disp_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk1("init_dv", disp_valid, 1'b1);
        chk("init_date", 64'({disp_year, disp_month, disp_day, disp_hour,
                              disp_minute, disp_second}),
            64'({16'h2024, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00}));
        wait_idle(20);
        chk("init_counter", counter, RESET_STAMP);

        for (int i = 0; i < 15; i++) do_event(vecs[i], $sformatf("vec%0d", i));

        // Set, adjust and tick together: served in that order.
        @(negedge clk);
        set_req = 1'b1; set_stamp = 64'd1000;
        adj_req = 1'b1; adj_unit = 2'd1; adj_dir = 1'b0;
        tick_1hz = 1'b1;
        sb_q.push_back(mk_exp(64'd1000));
        sb_q.push_back(mk_exp(64'd1060));
        sb_q.push_back(mk_exp(64'd1061));
        @(negedge clk);
        chk1("prio_set_ack", set_ack, 1'b1);
        chk1("prio_adj_ack_first", adj_ack, 1'b0);
        chk("prio_counter_set", counter, 64'd1000);
        set_req = 1'b0; tick_1hz = 1'b0;
        for (int n = 0; n < 20 && !adj_ack; n++) @(negedge clk);
        chk1("prio_adj_ack", adj_ack, 1'b1);
        chk("prio_counter_adj", counter, 64'd1060);
        adj_req = 1'b0;
        wait_idle(30);
        chk("prio_counter_tick", counter, 64'd1061);
        chk1("prio_overrun", overrun, 1'b0);

        // Three ticks inside one conversion window: one is lost.
        @(negedge clk);
        tick_1hz = 1'b1;
        sb_q.push_back(mk_exp(64'd1062));
        sb_q.push_back(mk_exp(64'd1063));
        @(negedge clk);
        tick_1hz = 1'b0;
        chk("ovr_counter_first", counter, 64'd1062);
        @(negedge clk);
        tick_1hz = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tick_1hz = 1'b0;
        wait_idle(30);
        chk("ovr_counter", counter, 64'd1063);
        chk1("ovr_flag", overrun, 1'b1);
        do_event(mkv(K_SET, 64'd500, 2'd0, 1'b0, 64'd500, 1'b0, 56'd0), "sticky");
        chk1("ovr_sticky", overrun, 1'b1);

        // Reset in the middle of a conversion: no disp_valid for it.
        @(negedge clk);
        set_req = 1'b1; set_stamp = 64'd777;
        @(negedge clk);
        set_req = 1'b0;
        chk1("mid_busy", busy, 1'b1);
        dc = disp_cnt;
        apply_reset();
        chk("mid_no_dv", 64'(disp_cnt), 64'(dc));
        wait_idle(20);
        chk("mid_one_dv", 64'(disp_cnt), 64'(dc + 1));

        // Five ticks from reset.
        alarm_cnt = 0;
        for (int i = 1; i <= 5; i++)
            do_event(mkv(K_TICK, 64'd0, 2'd0, 1'b0, RESET_STAMP + 64'(i), 1'b0, 56'd0),
                     $sformatf("tick%0d", i));
        chk("tick5_counter", counter, RESET_STAMP + 64'd5);
`ifdef STAMP_CTRL_ALARM_EN
        chk("alarm_count", 64'(alarm_cnt), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
